// File: rtl/batch_infer_seq.sv
// ---------------------------------------------------------------------------
// batch_infer_seq
//
// Sequences a batch of NUM_IMAGES inferences through an external inference
// core. For each image it launches the core, waits for its completion (or a
// timeout), compares the predicted class against the label ROM entry for
// that image, and accumulates the number of correct predictions.
//
// Ports
//   clk           : single clock, rising edge
//   reset         : asynchronous active-high reset
//   start         : batch request, honoured only in IDLE or FINISH
//   abort         : terminates a running batch (LAUNCH / WAIT)
//   core_start    : one-cycle launch pulse to the inference core (registered)
//   core_done     : core completion, honoured only in WAIT
//   core_class    : core prediction, valid with core_done
//   lbl_addr      : label ROM address (current image index)
//   lbl_data      : label ROM data, valid one cycle after lbl_addr changes
//   busy          : high in LAUNCH and WAIT
//   done          : high in FINISH
//   correct_count : number of predictions that matched their label
//   images_done   : number of images evaluated
//   last_class    : most recent core_class captured
//   timeout_err   : a WAIT ran TIMEOUT_CYC cycles without core_done
//   aborted       : the batch ended because of abort
// ---------------------------------------------------------------------------
module batch_infer_seq #(
    parameter int  NUM_IMAGES  = 100,
    parameter int  CLASS_W     = 4,
    parameter int  TIMEOUT_CYC = 65535,
    localparam int IDX_W       = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
    localparam int CNT_W       = $clog2(NUM_IMAGES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic               core_start,
    input  logic               core_done,
    input  logic [CLASS_W-1:0] core_class,
    output logic [IDX_W-1:0]   lbl_addr,
    input  logic [CLASS_W-1:0] lbl_data,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   correct_count,
    output logic [CNT_W-1:0]   images_done,
    output logic [CLASS_W-1:0] last_class,
    output logic               timeout_err,
    output logic               aborted
);

    // TIMEOUT_CYC is at most 65535, so a 16-bit wait counter suffices.
    localparam int WAIT_W = 16;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_IMAGES - 1);
    // The counter holds the number of idle WAIT cycles already spent, so the
    // TIMEOUT_CYC-th idle cycle is the one seen with the count at TIMEOUT_CYC-1.
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t             state_q,       state_d;
    logic [IDX_W-1:0]   index_q,       index_d;
    logic [WAIT_W-1:0]  wait_cnt_q,    wait_cnt_d;
    logic [CNT_W-1:0]   correct_q,     correct_d;
    logic [CNT_W-1:0]   images_q,      images_d;
    logic [CLASS_W-1:0] last_class_q,  last_class_d;
    logic               timeout_q,     timeout_d;
    logic               aborted_q,     aborted_d;
    logic               core_start_q,  core_start_d;

    logic               class_match;

    // Exact unsigned equality of the prediction against the label.
    assign class_match = (core_class == lbl_data);

    // -----------------------------------------------------------------------
    // Next-state and result logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        wait_cnt_d   = wait_cnt_q;
        correct_d    = correct_q;
        images_d     = images_q;
        last_class_d = last_class_q;
        timeout_d    = timeout_q;
        aborted_d    = aborted_q;
        // The launch pulse is registered: it is set only on the edge that
        // enters LAUNCH, so it is high for exactly the LAUNCH cycle.
        core_start_d = 1'b0;

        unique case (state_q)
            S_IDLE, S_FINISH: begin
                // last_class is deliberately kept across batches.
                if (start) begin
                    index_d      = '0;
                    correct_d    = '0;
                    images_d     = '0;
                    timeout_d    = 1'b0;
                    aborted_d    = 1'b0;
                    state_d      = S_LAUNCH;
                    core_start_d = 1'b1;
                end
            end

            S_LAUNCH: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                // Priority: abort, then completion, then timeout.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_FINISH;
                end else if (core_done) begin
                    last_class_d = core_class;
                    // Bounded by NUM_IMAGES, so the counters cannot wrap.
                    images_d     = images_q + CNT_W'(1);
                    if (class_match) begin
                        correct_d = correct_q + CNT_W'(1);
                    end
                    if (index_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        index_d      = index_q + IDX_W'(1);
                        state_d      = S_LAUNCH;
                        core_start_d = 1'b1;
                    end
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            index_q      <= '0;
            wait_cnt_q   <= '0;
            correct_q    <= '0;
            images_q     <= '0;
            last_class_q <= '0;
            timeout_q    <= 1'b0;
            aborted_q    <= 1'b0;
            core_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            wait_cnt_q   <= wait_cnt_d;
            correct_q    <= correct_d;
            images_q     <= images_d;
            last_class_q <= last_class_d;
            timeout_q    <= timeout_d;
            aborted_q    <= aborted_d;
            core_start_q <= core_start_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The index only moves on the completion edge that re-enters LAUNCH, so
    // the address is stable from LAUNCH through WAIT and the ROM data has at
    // least one cycle to settle before the earliest possible capture.
    assign lbl_addr      = index_q;
    assign core_start    = core_start_q;
    assign busy          = (state_q == S_LAUNCH) || (state_q == S_WAIT);
    assign done          = (state_q == S_FINISH);
    assign correct_count = correct_q;
    assign images_done   = images_q;
    assign last_class    = last_class_q;
    assign timeout_err   = timeout_q;
    assign aborted       = aborted_q;

endmodule

// File: tb/tb_batch_infer_seq.sv
// ---------------------------------------------------------------------------
// tb_batch_infer_seq
//
// Two instances of batch_infer_seq (4 images and 1 image per batch, both
// with a 10-cycle timeout), each with a registered label ROM and a core
// responder. A behavioural model tracks what every output must be and is
// compared on every falling edge; directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_batch_infer_seq;

    localparam int TO = 10;
    localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_WAIT = 2, PH_FINISH = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // stimulus controls
    logic       start_tb [2];
    logic       abort_tb [2];
    logic       inj_done [2];
    logic [3:0] inj_cls  [2];
    bit         rand_mode;
    int         fixed_lat [2];
    int         never_idx [2];
    int         aod_idx   [2];   // abort together with core_done on this image
    int         labels [2][4];
    int         resp   [2][4];

    // DUT input nets and observed outputs
    logic        in_abort [2];
    logic        in_done  [2];
    logic [3:0]  in_cls   [2];
    logic        o_busy [2], o_done [2], o_cs [2], o_to [2], o_ab [2];
    logic [31:0] o_addr [2], o_corr [2], o_imgs [2], o_last [2];
    int          cs_total [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int N  = (gi == 0) ? 4 : 1;
        localparam int IW = (N > 1) ? $clog2(N) : 1;
        localparam int NW = $clog2(N + 1);

        logic          cs, busy, done, to_err, abrt;
        logic [IW-1:0] addr;
        logic [3:0]    lbl_q, last;
        logic [NW-1:0] corr, imgs;
        logic          resp_done;
        logic [3:0]    resp_cls;
        logic          active;
        int            age, cur_lat;

        assign in_done[gi]  = resp_done | inj_done[gi];
        assign in_cls[gi]   = inj_done[gi] ? inj_cls[gi] : resp_cls;
        assign in_abort[gi] = abort_tb[gi] |
                              ((aod_idx[gi] >= 0) && resp_done && (int'(addr) == aod_idx[gi]));

        batch_infer_seq #(
            .NUM_IMAGES (N),
            .CLASS_W    (4),
            .TIMEOUT_CYC(TO)
        ) u_dut (
            .clk          (clk),
            .reset        (rst),
            .start        (start_tb[gi]),
            .abort        (in_abort[gi]),
            .core_start   (cs),
            .core_done    (in_done[gi]),
            .core_class   (in_cls[gi]),
            .lbl_addr     (addr),
            .lbl_data     (lbl_q),
            .busy         (busy),
            .done         (done),
            .correct_count(corr),
            .images_done  (imgs),
            .last_class   (last),
            .timeout_err  (to_err),
            .aborted      (abrt)
        );

        // registered-read label ROM
        always @(posedge clk) lbl_q <= 4'(labels[gi][addr]);

        // core responder: done arrives cur_lat cycles after the launch cycle
        // (cur_lat == 0 means the core never answers)
        always @(negedge clk) begin
            if (rst) begin
                active    <= 1'b0;
                resp_done <= 1'b0;
                age       <= 0;
                cur_lat   <= 0;
                resp_cls  <= 4'd0;
            end else begin
                resp_done <= 1'b0;
                if (cs) begin
                    active <= 1'b1;
                    age    <= 1;
                    if (rand_mode) begin
                        cur_lat  <= int'($urandom_range(1, 12));
                        resp_cls <= ($urandom_range(0, 1) == 1) ? 4'(labels[gi][addr])
                                                                : 4'($urandom_range(0, 15));
                    end else begin
                        cur_lat  <= (never_idx[gi] == int'(addr)) ? 0 : fixed_lat[gi];
                        resp_cls <= 4'(resp[gi][addr]);
                    end
                end else if (active) begin
                    if (cur_lat != 0 && age == cur_lat) begin
                        resp_done <= 1'b1;
                        active    <= 1'b0;
                    end else begin
                        age <= age + 1;
                    end
                end
            end
        end

        assign o_busy[gi] = busy;
        assign o_done[gi] = done;
        assign o_cs[gi]   = cs;
        assign o_to[gi]   = to_err;
        assign o_ab[gi]   = abrt;
        assign o_addr[gi] = 32'(addr);
        assign o_corr[gi] = 32'(corr);
        assign o_imgs[gi] = 32'(imgs);
        assign o_last[gi] = 32'(last);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) if (o_cs[i]) cs_total[i] <= cs_total[i] + 1;
    end

    // ------------------------------------------------------------------
    // Behavioural model: per instance, what the batch has achieved so far
    // ------------------------------------------------------------------
    typedef struct packed {
        int ph;     // IDLE / LAUNCH / WAIT / FINISH
        int idx;    // image being worked on
        int wcnt;   // idle WAIT cycles spent on this image
        int corr;
        int imgs;
        int last;
        int to;
        int ab;
        int cs;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t step(mdl_t s, int i, logic st, logic ab, logic cd, int cls);
        mdl_t n = s;
        int   last_img = (i == 0) ? 3 : 0;
        n.cs = 0;
        if (s.ph == PH_IDLE || s.ph == PH_FINISH) begin
            if (st) begin
                n.idx = 0; n.corr = 0; n.imgs = 0; n.to = 0; n.ab = 0;
                n.ph = PH_LAUNCH; n.cs = 1;
            end
        end else if (ab) begin
            n.ab = 1; n.ph = PH_FINISH;
        end else if (s.ph == PH_LAUNCH) begin
            n.wcnt = 0; n.ph = PH_WAIT;
        end else if (cd) begin
            n.last = cls;
            n.imgs = s.imgs + 1;
            if (cls == labels[i][s.idx]) n.corr = s.corr + 1;
            if (s.idx == last_img) n.ph = PH_FINISH;
            else begin n.idx = s.idx + 1; n.ph = PH_LAUNCH; n.cs = 1; end
        end else if (s.wcnt + 1 == TO) begin
            n.to = 1; n.ph = PH_FINISH;
        end else begin
            n.wcnt = s.wcnt + 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) m[i] <= '0;
            else     m[i] <= step(m[i], i, start_tb[i], in_abort[i], in_done[i], int'(in_cls[i]));
        end
    end

    task automatic check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("i%0d_busy", i),  int'(o_busy[i]), int'(m[i].ph == PH_LAUNCH || m[i].ph == PH_WAIT));
            check($sformatf("i%0d_done", i),  int'(o_done[i]), int'(m[i].ph == PH_FINISH));
            check($sformatf("i%0d_cstart", i), int'(o_cs[i]),  m[i].cs);
            check($sformatf("i%0d_addr", i),  int'(o_addr[i]), m[i].idx);
            check($sformatf("i%0d_correct", i), int'(o_corr[i]), m[i].corr);
            check($sformatf("i%0d_images", i), int'(o_imgs[i]), m[i].imgs);
            check($sformatf("i%0d_last", i),  int'(o_last[i]), m[i].last);
            check($sformatf("i%0d_timeout", i), int'(o_to[i]), m[i].to);
            check($sformatf("i%0d_aborted", i), int'(o_ab[i]), m[i].ab);
        end
    end

    task automatic pulse_start(int i);
        start_tb[i] = 1'b1;
        @(negedge clk);
        start_tb[i] = 1'b0;
    endtask

    task automatic wait_done(int i, int budget, string nm);
        int k = 0;
        while (!o_done[i] && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (!o_done[i]) begin
            n_fail++;
            $display("FAIL %s: done not seen within %0d cycles", nm, budget);
        end
    endtask

    task automatic results(string nm, int i, int corr, int imgs, int last, int to, int ab);
        check({nm, "_correct"}, int'(o_corr[i]), corr);
        check({nm, "_images"},  int'(o_imgs[i]), imgs);
        check({nm, "_last"},    int'(o_last[i]), last);
        check({nm, "_timeout"}, int'(o_to[i]),   to);
        check({nm, "_aborted"}, int'(o_ab[i]),   ab);
        $display("txn %s: correct=%0d images=%0d last=%0d timeout=%0d aborted=%0d",
                 nm, o_corr[i], o_imgs[i], o_last[i], o_to[i], o_ab[i]);
    endtask

    initial begin
        int c0, since, k;
        rst = 1'b1;
        rand_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_tb[i] = 1'b0; abort_tb[i] = 1'b0; inj_done[i] = 1'b0; inj_cls[i] = 4'd0;
            never_idx[i] = -1; aod_idx[i] = -1;
        end
        fixed_lat[0] = 5; fixed_lat[1] = 2;
        labels[0] = '{3, 7, 1, 9}; resp[0] = '{3, 7, 2, 9};
        labels[1] = '{5, 0, 0, 0}; resp[1] = '{5, 0, 0, 0};
        repeat (3) @(negedge clk);
        check("rst_busy", int'(o_busy[0]), 0);
        check("rst_done", int'(o_done[0]), 0);
        check("rst_images", int'(o_imgs[0]), 0);
        check("rst_cstart", int'(o_cs[1]), 0);
        rst = 1'b0;
        @(negedge clk);

        // full 4-image batch, one mismatch
        c0 = cs_total[0];
        pulse_start(0);
        wait_done(0, 200, "batch4");
        results("batch4", 0, 3, 4, 9, 0, 0);
        check("batch4_launches", cs_total[0] - c0, 4);

        // core never answers image 2: timeout after 10 WAIT cycles
        never_idx[0] = 2;
        since = 0;
        pulse_start(0);
        for (k = 0; k < 200; k++) begin
            if (o_done[0]) break;
            if (o_cs[0]) since = 0; else since++;
            @(negedge clk);
        end
        check("timeout_seen_done", int'(o_done[0]), 1);
        check("timeout_wait_cycles", since, TO);
        results("timeout", 0, 2, 2, 7, 1, 0);
        never_idx[0] = -1;

        // abort in the same cycle as core_done of image 1
        aod_idx[0] = 1;
        pulse_start(0);
        wait_done(0, 200, "abort");
        results("abort", 0, 1, 1, 3, 0, 1);
        aod_idx[0] = -1;

        // core_done injected in IDLE, start repeated while busy
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        inj_done[0] = 1'b1; inj_cls[0] = 4'd3;
        repeat (3) @(negedge clk);
        inj_done[0] = 1'b0;
        @(negedge clk);
        results("idle_inject", 0, 0, 0, 0, 0, 0);
        c0 = cs_total[0];
        pulse_start(0);
        for (k = 0; k < 200; k++) begin
            start_tb[0] = o_busy[0] && (o_addr[0] != 3);
            if (o_done[0]) break;
            @(negedge clk);
        end
        start_tb[0] = 1'b0;
        check("restart_busy_done", int'(o_done[0]), 1);
        results("restart_busy", 0, 3, 4, 9, 0, 0);
        check("restart_busy_launches", cs_total[0] - c0, 4);

        // reset during WAIT of the last image, then a fresh batch
        pulse_start(0);
        for (k = 0; k < 200; k++) begin
            if (o_busy[0] && !o_cs[0] && o_addr[0] == 3) break;
            @(negedge clk);
        end
        check("midreset_reached", int'(o_addr[0]), 3);
        check("midreset_images_before", int'(o_imgs[0]), 3);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_busy", int'(o_busy[0]), 0);
        results("midreset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        c0 = cs_total[0];
        rst = 1'b0; start_tb[0] = 1'b1;
        @(negedge clk);
        start_tb[0] = 1'b0;
        check("release_start_cstart", int'(o_cs[0]), 1);
        wait_done(0, 200, "after_reset");
        results("after_reset", 0, 3, 4, 9, 0, 0);
        check("after_reset_launches", cs_total[0] - c0, 4);

        // single-image instance, back-to-back batches
        pulse_start(1);
        wait_done(1, 100, "single_a");
        results("single_a", 1, 1, 1, 5, 0, 0);
        resp[1][0] = 6;
        pulse_start(1);
        check("single_done_drop", int'(o_done[1]), 0);
        check("single_rerun_cstart", int'(o_cs[1]), 1);
        wait_done(1, 100, "single_b");
        results("single_b", 1, 0, 1, 6, 0, 0);

        // randomized traffic on both instances
        rst = 1'b1;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++) labels[i][j] = int'($urandom_range(0, 15));
        rand_mode = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4000) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                start_tb[i] = ($urandom_range(0, 24) == 0);
                abort_tb[i] = ($urandom_range(0, 79) == 0);
                inj_done[i] = ($urandom_range(0, 39) == 0);
                inj_cls[i]  = 4'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 699) == 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_tb[i] = 1'b0; abort_tb[i] = 1'b0; inj_done[i] = 1'b0;
        end
        repeat (30) @(negedge clk);
        $display("txn random: launches inst0=%0d inst1=%0d", cs_total[0], cs_total[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
